shift_seq_ctrl: RTL

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a downstream 4-bit universal shift register: load, N shifts, done pulse.
// Optional macro SHIFT_SEQ_SHADOW_EN adds shadow_q, a model of the downstream register contents.
module shift_seq_ctrl #(
  parameter int MAX_SHIFT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_dir,
  input  logic [2:0] in_count,
  output logic [1:0] mode,
  output logic [3:0] par_out,
  output logic       busy,
  output logic       done
`ifdef SHIFT_SEQ_SHADOW_EN
  ,
  output logic [3:0] shadow_q
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_RIGHT = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;
  localparam logic [2:0] MAX_C   = 3'(MAX_SHIFT);

  state_e     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic       dir_q, dir_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend only on state and captured job registers (Moore).
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    mode     = M_HOLD;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_dir;
          cnt_d   = (in_count > MAX_C) ? MAX_C : in_count;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mode    = M_LOAD;
        state_d = (cnt_q == 3'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        mode  = dir_q ? M_LEFT : M_RIGHT;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign par_out = data_q;

`ifdef SHIFT_SEQ_SHADOW_EN
  logic [3:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    case (state_q)
      LOAD:    shadow_d = data_q;
      SHIFT:   shadow_d = dir_q ? {shadow_q[2:0], 1'b0} : {1'b0, shadow_q[3:1]};
      default: shadow_d = shadow_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end
`endif

endmodule
